// File: rtl/kb_event_fifo_pkg.sv
// Shared definitions for the PS/2 keyboard event path: scan-code constants,
// parser state encodings, event field layout and small helpers.
package kb_event_fifo_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_EXT       = 8'hE0;
  localparam logic [7:0] SC_BRK       = 8'hF0;

  // Status / error bytes that never become key events
  localparam logic [7:0] SC_BAT       = 8'hAA;
  localparam logic [7:0] SC_ACK       = 8'hFA;
  localparam logic [7:0] SC_RESEND    = 8'hFE;
  localparam logic [7:0] SC_ERR0      = 8'h00;
  localparam logic [7:0] SC_ERR1      = 8'hFF;
  localparam logic [7:0] SC_ECHO_FAIL = 8'hFC;

  // Parser states, kept as plain constants for legacy tools
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXT    = 2'd1;
  localparam logic [1:0] ST_BRK    = 2'd2;
  localparam logic [1:0] ST_EXTBRK = 2'd3;

  // Event word layout: {brk, ext, code[7:0]}
  localparam int EV_W       = 10;
  localparam int EV_BRK_BIT = 9;
  localparam int EV_EXT_BIT = 8;

  // Bytes that abort any pending prefix and are never queued
  function automatic logic is_filtered(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_BAT) || (b == SC_ACK) ||
           (b == SC_ECHO_FAIL) || (b == SC_RESEND) || (b == SC_ERR1);
  endfunction

  // Pack an event word
  function automatic logic [EV_W-1:0] make_event(input logic brk, input logic ext,
                                                 input logic [7:0] code);
    return {brk, ext, code};
  endfunction

endpackage

// File: rtl/kb_event_fifo_sync_fifo.sv
// Synchronous FIFO with registered write and head-of-queue read port.
// No fall-through: a push into an empty FIFO becomes visible one cycle later.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // A pop needs data; a push into a full FIFO only succeeds alongside a pop
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state for storage, pointers (wrap modulo DEPTH) and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers, fully cleared on reset so a reset also flushes queued events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/kb_event_fifo.sv
// PS/2 keyboard event front end in the system clock domain: synchronises the
// byte toggle, parses E0/F0 prefixes into {brk, ext, code} events and queues
// them for the consumer with a sticky overflow flag.
module kb_event_fifo
  import kb_event_fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int EMIT_BREAK = 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [7:0]             key_code,
  input  logic                   key_tgl,
  output logic [9:0]             ev_data,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic                   ovf,
  input  logic                   ovf_clr,
  output logic [$clog2(DEPTH):0] level
);

  localparam logic EMIT_EN = (EMIT_BREAK != 0);

  // Toggle synchroniser; s1 is the metastability catcher
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic strobe;

  // Captured byte, one cycle after the strobe
  logic [7:0] byte_q, byte_d;
  logic       byte_vld_q, byte_vld_d;

  // Parser state and registered push request toward the FIFO
  logic [1:0]      state_q, state_d;
  logic            push_q, push_d;
  logic [EV_W-1:0] push_data_q, push_data_d;

  // Overflow flag and FIFO handshake
  logic ovf_q, ovf_d;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_push;
  logic pop;
  logic drop;

  assign strobe    = s2_q ^ s3_q;
  assign ev_valid  = ~fifo_empty;
  assign pop       = ev_valid & ev_ready;
  assign drop      = push_q & fifo_full & ~pop;
  assign fifo_push = push_q & ~drop;
  assign ovf       = ovf_q;

  // Synchroniser shift and byte capture on each detected toggle edge
  always_comb begin
    s1_d       = key_tgl;
    s2_d       = s1_q;
    s3_d       = s2_q;
    byte_vld_d = strobe;
    byte_d     = strobe ? key_code : byte_q;
  end

  // Prefix parser: one byte per strobe, holds state otherwise
  always_comb begin
    state_d     = state_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    if (byte_vld_q) begin
      if (is_filtered(byte_q)) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (byte_q == SC_EXT) begin
              state_d = ST_EXT;
            end else if (byte_q == SC_BRK) begin
              state_d = ST_BRK;
            end else begin
              push_d      = 1'b1;
              push_data_d = make_event(1'b0, 1'b0, byte_q);
              state_d     = ST_IDLE;
            end
          end
          ST_EXT: begin
            if (byte_q == SC_BRK) begin
              state_d = ST_EXTBRK;
            end else if (byte_q == SC_EXT) begin
              state_d = ST_EXT;
            end else begin
              push_d      = 1'b1;
              push_data_d = make_event(1'b0, 1'b1, byte_q);
              state_d     = ST_IDLE;
            end
          end
          ST_BRK: begin
            if (byte_q == SC_BRK) begin
              state_d = ST_BRK;
            end else if (byte_q == SC_EXT) begin
              state_d = ST_EXTBRK;
            end else begin
              push_d      = EMIT_EN;
              push_data_d = make_event(1'b1, 1'b0, byte_q);
              state_d     = ST_IDLE;
            end
          end
          ST_EXTBRK: begin
            if ((byte_q == SC_BRK) || (byte_q == SC_EXT)) begin
              state_d = ST_EXTBRK;
            end else begin
              push_d      = EMIT_EN;
              push_data_d = make_event(1'b1, 1'b1, byte_q);
              state_d     = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Control and pipeline registers; reset drops any partial prefix
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      state_q     <= ST_IDLE;
      push_q      <= 1'b0;
      push_data_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      byte_q      <= byte_d;
      byte_vld_q  <= byte_vld_d;
      state_q     <= state_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      ovf_q       <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (fifo_push),
    .push_data (push_data_q),
    .pop       (pop),
    .rd_data   (ev_data),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_kb_event_fifo.sv
// Bench for kb_event_fifo: two instances (DEPTH=4 with break events, DEPTH=16
// without) share one byte stream; a queue-based event model is compared every
// cycle, and literal expectations pin the model at key points.
module tb_kb_event_fifo;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] key_code;
  logic       key_tgl;
  logic       ev_ready;
  logic       ovf_clr;

  logic [9:0] ev_data_a, ev_data_b;
  logic       ev_valid_a, ev_valid_b;
  logic       ovf_a, ovf_b;
  logic [2:0] level_a;
  logic [4:0] level_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  kb_event_fifo #(.DEPTH(4), .EMIT_BREAK(1)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .key_code(key_code), .key_tgl(key_tgl),
    .ev_data(ev_data_a), .ev_valid(ev_valid_a), .ev_ready(ev_ready),
    .ovf(ovf_a), .ovf_clr(ovf_clr), .level(level_a)
  );

  kb_event_fifo #(.DEPTH(16), .EMIT_BREAK(0)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .key_code(key_code), .key_tgl(key_tgl),
    .ev_data(ev_data_b), .ev_valid(ev_valid_b), .ev_ready(ev_ready),
    .ovf(ovf_b), .ovf_clr(ovf_clr), .level(level_b)
  );

  // Behavioural model: prefix flags, event queues, overflow flags
  logic [9:0] mq [2][$];
  bit         m_ext [2];
  bit         m_brk [2];
  bit         m_ovf [2];
  int         m_depth [2] = '{4, 16};
  bit         m_emit  [2] = '{1'b1, 1'b0};
  bit         pend_v   = 1'b0;
  logic [7:0] pend_b   = 8'h00;
  int         pend_cnt = 0;

  function automatic bit filtered(input logic [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hFA || b == 8'hFC || b == 8'hFE || b == 8'hFF;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_ext[i] = 1'b0;
      m_brk[i] = 1'b0;
      m_ovf[i] = 1'b0;
    end
    pend_v = 1'b0;
  endtask

  // A byte flipped before edge N lands in the queue at edge N+4
  task automatic model_edge();
    bit fire;
    fire = 1'b0;
    if (pend_v) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        fire   = 1'b1;
        pend_v = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      bit         pop, has_ev, drop;
      logic [9:0] ev;
      int         sz;
      sz     = mq[i].size();
      pop    = (sz > 0) && ev_ready;
      has_ev = 1'b0;
      drop   = 1'b0;
      ev     = '0;
      if (fire) begin
        if (pend_b == 8'hE0) m_ext[i] = 1'b1;
        else if (pend_b == 8'hF0) m_brk[i] = 1'b1;
        else begin
          if (!filtered(pend_b) && (!m_brk[i] || m_emit[i])) begin
            has_ev = 1'b1;
            ev     = {m_brk[i], m_ext[i], pend_b};
          end
          m_ext[i] = 1'b0;
          m_brk[i] = 1'b0;
        end
      end
      if (pop) void'(mq[i].pop_front());
      if (has_ev) begin
        if (sz < m_depth[i] || pop) mq[i].push_back(ev);
        else drop = 1'b1;
      end
      if (drop) m_ovf[i] = 1'b1;
      else if (ovf_clr) m_ovf[i] = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      if (!RST_N) model_clear();
      else model_edge();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (RST_N) begin
        chk("a_valid", 32'(ev_valid_a), 32'(mq[0].size() > 0));
        chk("a_data",  32'(ev_data_a),  32'(mq[0].size() > 0 ? mq[0][0] : 10'h000));
        chk("a_level", 32'(level_a),    32'(mq[0].size()));
        chk("a_ovf",   32'(ovf_a),      32'(m_ovf[0]));
        chk("b_valid", 32'(ev_valid_b), 32'(mq[1].size() > 0));
        chk("b_data",  32'(ev_data_b),  32'(mq[1].size() > 0 ? mq[1][0] : 10'h000));
        chk("b_level", 32'(level_b),    32'(mq[1].size()));
        chk("b_ovf",   32'(ovf_b),      32'(m_ovf[1]));
      end
    end
  end

  // Flip the toggle at the current negedge and arm the model
  task automatic flip(input logic [7:0] b);
    key_code = b;
    key_tgl  = ~key_tgl;
    pend_b   = b;
    pend_cnt = 5;
    pend_v   = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    flip(b);
    repeat (10) @(negedge CLK);
  endtask

  task automatic drain(input int n);
    @(negedge CLK);
    ev_ready = 1'b1;
    repeat (n) @(negedge CLK);
    ev_ready = 1'b0;
  endtask

  logic [7:0] makes [6] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36};

  initial begin
    RST_N    = 1'b0;
    key_tgl  = 1'b0;
    key_code = 8'h00;
    ev_ready = 1'b0;
    ovf_clr  = 1'b0;
    model_clear();
    repeat (3) @(negedge CLK);
    chk("rst_valid", 32'(ev_valid_a), 32'd0);
    chk("rst_data",  32'(ev_data_a),  32'd0);
    chk("rst_level", 32'(level_a),    32'd0);
    chk("rst_ovf",   32'(ovf_a),      32'd0);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);

    // 1: single make byte, latency of four edges
    @(negedge CLK);
    flip(8'h1C);
    repeat (4) @(posedge CLK);
    #1 chk("t1_valid_early", 32'(ev_valid_a), 32'd0);
    @(posedge CLK);
    #1 chk("t1_valid", 32'(ev_valid_a), 32'd1);
    chk("t1_data", 32'(ev_data_a), 32'h01C);
    repeat (6) @(negedge CLK);
    drain(1);
    @(negedge CLK);
    chk("t1_empty", 32'(ev_valid_a), 32'd0);
    chk("t1_level", 32'(level_a), 32'd0);
    drain(2);

    // 2: break sequence
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk("t2_a_data", 32'(ev_data_a), 32'h21C);
    chk("t2_b_level", 32'(level_b), 32'd0);
    drain(3);

    // 3: extended make then extended break
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    chk("t3_a_level", 32'(level_a), 32'd2);
    chk("t3_a_head", 32'(ev_data_a), 32'h175);
    chk("t3_b_level", 32'(level_b), 32'd1);
    drain(1);
    @(negedge CLK);
    chk("t3_a_second", 32'(ev_data_a), 32'h375);
    drain(3);

    // 4: filtered bytes, FE aborts an extended prefix
    send_byte(8'hAA);
    send_byte(8'hFA);
    send_byte(8'hE0);
    send_byte(8'hFE);
    send_byte(8'h1C);
    chk("t4_a_level", 32'(level_a), 32'd1);
    chk("t4_a_data", 32'(ev_data_a), 32'h01C);
    drain(3);

    // 5: overflow on the DEPTH=4 instance
    for (int i = 0; i < 6; i++) send_byte(makes[i]);
    chk("t5_a_level", 32'(level_a), 32'd4);
    chk("t5_a_ovf", 32'(ovf_a), 32'd1);
    chk("t5_a_head", 32'(ev_data_a), 32'h016);
    chk("t5_b_level", 32'(level_b), 32'd6);
    chk("t5_b_ovf", 32'(ovf_b), 32'd0);
    // push and pop in the same cycle while full
    @(negedge CLK);
    flip(8'h3D);
    repeat (4) @(negedge CLK);
    ev_ready = 1'b1;
    @(negedge CLK);
    ev_ready = 1'b0;
    chk("t5_pp_level", 32'(level_a), 32'd4);
    chk("t5_pp_head", 32'(ev_data_a), 32'h01E);
    repeat (6) @(negedge CLK);
    // drop coinciding with a clear keeps the flag set
    @(negedge CLK);
    flip(8'h3E);
    repeat (4) @(negedge CLK);
    ovf_clr = 1'b1;
    @(negedge CLK);
    ovf_clr = 1'b0;
    chk("t5_set_wins", 32'(ovf_a), 32'd1);
    repeat (6) @(negedge CLK);
    ovf_clr = 1'b1;
    @(negedge CLK);
    ovf_clr = 1'b0;
    chk("t5_ovf_clr", 32'(ovf_a), 32'd0);
    drain(20);

    // 6: reset with a pending prefix and queued events
    send_byte(8'h16);
    send_byte(8'h1E);
    send_byte(8'h26);
    send_byte(8'hE0);
    chk("t6_pre_level", 32'(level_a), 32'd3);
    RST_N   = 1'b0;
    key_tgl = 1'b0;
    model_clear();
    repeat (2) @(negedge CLK);
    chk("t6_rst_valid", 32'(ev_valid_a), 32'd0);
    chk("t6_rst_level", 32'(level_a), 32'd0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    send_byte(8'h1C);
    chk("t6_a_data", 32'(ev_data_a), 32'h01C);
    chk("t6_b_data", 32'(ev_data_b), 32'h01C);
    drain(2);
    repeat (2) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
